// File: rtl/input_fetch_pkg.sv
// input_fetch_pkg: shared row geometry and fetch FSM state encoding
package input_fetch_pkg;
    localparam int unsigned ROW_W  = 2048;
    localparam int unsigned ADDR_W = 6;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/row_fifo.sv
// row_fifo: small synchronous FIFO with async active-high reset, simultaneous push/pop allowed
module row_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];
    // Storage, pointers and occupancy; a pop frees the slot a same-cycle push may take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/input_row_fetcher.sv
// input_row_fetcher: walks input memory port B over a row run and streams rows out under credit-limited backpressure; optional INPUT_FETCH_PERF_EN adds a stall counter
module input_row_fetcher #(
    parameter int unsigned ROW_W      = input_fetch_pkg::ROW_W,
    parameter int unsigned ADDR_W     = input_fetch_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_row,
    input  logic [ADDR_W:0]   num_rows,
    output logic              mem_en_b,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [ROW_W-1:0]  mem_dout_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ROW_W-1:0]  m_data,
    output logic [ADDR_W-1:0] m_row,
    output logic              m_last,
    output logic              busy,
    output logic              done
`ifdef INPUT_FETCH_PERF_EN
    ,output logic [31:0]      perf_stall_cycles
`endif
);
    import input_fetch_pkg::*;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW = ROW_W + ADDR_W + 1;
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] addr, fl_row;
    logic [ADDR_W:0]   remaining;
    logic              in_flight, fl_last, issue, pop, credit, full, empty, last_issue;
    logic [CW-1:0]     count, occ;
    logic [FW-1:0]     head;
    row_fifo #(.DEPTH(FIFO_DEPTH), .W(FW), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight),
        .din   ({mem_dout_b, fl_row, fl_last}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign {m_data, m_row, m_last} = head;
    assign m_valid    = !empty;
    assign pop        = m_valid && m_ready;
    assign occ        = count - CW'(pop);
    assign credit     = (!full || pop) && ({1'b0, occ} + (CW + 1)'(in_flight) < (CW + 1)'(FIFO_DEPTH));
    assign mem_addr_b = addr;
    assign issue      = mem_en_b;
    assign last_issue = remaining == (ADDR_W + 1)'(1);
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // FSM next state: a zero-length run never leaves IDLE
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start && num_rows != '0) state_nxt = FETCH;
        if (state == FETCH && issue && last_issue)    state_nxt = DRAIN;
        if (state == DRAIN && pop && m_last)          state_nxt = IDLE;
    end
    // FSM outputs: a read is issued only while a buffer slot is guaranteed for its data
    always_comb begin
        mem_en_b = (state == FETCH) && credit;
        busy     = state != IDLE;
    end
    // Row address/count, in-flight tag for the 1-cycle read latency, and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            fl_row    <= '0;
            fl_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= (state == IDLE && start && num_rows == '0) || (state == DRAIN && pop && m_last);
            in_flight <= issue;
            if (issue) begin
                fl_row    <= addr;
                fl_last   <= last_issue;
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end else if (state == IDLE && start) begin
                addr      <= start_row;
                remaining <= num_rows;
            end
        end
    end
`ifdef INPUT_FETCH_PERF_EN
    // Saturating count of cycles the consumer holds off a valid row
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              perf_stall_cycles <= '0;
        else if (state == IDLE && start)                      perf_stall_cycles <= '0;
        else if (m_valid && !m_ready && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_input_row_fetcher.sv
// tb_input_row_fetcher: randomized self-checking bench with a memory model and expected row-sequence reference
module tb_input_row_fetcher;
    localparam int RW = 2048;
    localparam int AW = 6;
    logic clk = 0, rst = 1, start = 0, m_ready = 0;
    logic [AW-1:0] start_row = '0;
    logic [AW:0] num_rows = '0;
    logic mem_en_b, m_valid, m_last, busy, done;
    logic [AW-1:0] mem_addr_b, m_row;
    logic [RW-1:0] mem_dout_b = '0;
    logic [RW-1:0] m_data;
`ifdef INPUT_FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif
    logic [RW-1:0] mem [64];
    typedef struct {int c; logic [AW-1:0] row; logic last; logic [RW-1:0] data;} beat_t;
    beat_t beats[$];
    int done_cyc[$];
    int cyc = 0, en_cnt = 0, valid_cnt = 0, busy_cnt = 0, bound_viol = 0, outstanding = 0;
    int tests = 0, fails = 0;

    input_row_fetcher dut (
        .clk(clk), .rst(rst), .start(start), .start_row(start_row), .num_rows(num_rows),
        .mem_en_b(mem_en_b), .mem_addr_b(mem_addr_b), .mem_dout_b(mem_dout_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row), .m_last(m_last),
        .busy(busy), .done(done)
`ifdef INPUT_FETCH_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Port-B memory: 1-cycle read latency
    always @(posedge clk) if (mem_en_b) mem_dout_b <= mem[mem_addr_b];
    // Monitor: accepted rows, done pulses, and rows outstanding (issued but not yet consumed)
    always @(negedge clk) begin
        if (rst) outstanding = 0;
        else begin
            if (mem_en_b && outstanding - int'(m_valid && m_ready) >= 2) bound_viol++;
            outstanding = outstanding - int'(m_valid && m_ready) + int'(mem_en_b);
            if (m_valid && m_ready) beats.push_back('{cyc, m_row, m_last, m_data});
            if (done) done_cyc.push_back(cyc);
            en_cnt += int'(mem_en_b);
            valid_cnt += int'(m_valid);
            busy_cnt += int'(busy);
        end
    end

    task automatic clear_mon();
        beats.delete();
        done_cyc.delete();
        en_cnt = 0; valid_cnt = 0; busy_cnt = 0; bound_viol = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One run: mode 0 keeps m_ready high, mode 1 randomizes it every cycle
    task automatic run(input logic [AW-1:0] sr, input int n, input int mode, output int t0, output bit timeout);
        clear_mon();
        tick();
        start = 1; start_row = sr; num_rows = 7'(n); t0 = cyc;
        m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        start = 0; start_row = 6'($urandom); num_rows = 7'($urandom);
        timeout = 1;
        for (int k = 0; k < 1000; k++) begin
            if (done_cyc.size() > 0) begin timeout = 0; break; end
            if (mode != 0) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1;
        tests++;
        if (timeout) begin fails++; $display("FAIL run_timeout start_row=%0d n=%0d: no done within 1000 cycles", sr, n); end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        tests += 8;
        if (mem_en_b !== 1'b0)   begin fails++; $display("FAIL reset_mem_en_b got %b want 0", mem_en_b); end
        if (mem_addr_b !== '0)   begin fails++; $display("FAIL reset_mem_addr_b got %0d want 0", mem_addr_b); end
        if (m_valid !== 1'b0)    begin fails++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        if (m_data !== '0)       begin fails++; $display("FAIL reset_m_data got %h want 0", m_data[31:0]); end
        if (m_row !== '0)        begin fails++; $display("FAIL reset_m_row got %0d want 0", m_row); end
        if (m_last !== 1'b0)     begin fails++; $display("FAIL reset_m_last got %b want 0", m_last); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)       begin fails++; $display("FAIL reset_done got %b want 0", done); end
`ifdef INPUT_FETCH_PERF_EN
        tests++;
        if (perf_stall_cycles !== '0) begin fails++; $display("FAIL reset_perf got %0d want 0", perf_stall_cycles); end
`endif
        rst = 0;
        tick();
    endtask

    // Streaming with m_ready high: exact per-row cycle timing, last flag and done cycle
    task automatic test_stream(input string nm, input logic [AW-1:0] sr, input int n);
        int t0; bit to; logic [AW-1:0] er;
        run(sr, n, 0, t0, to);
        tests++;
        if (beats.size() != n) begin fails++; $display("FAIL %s_count got %0d want %0d", nm, beats.size(), n); end
        for (int i = 0; i < beats.size() && i < n; i++) begin
            er = 6'(int'(sr) + i);
            tests++;
            if (beats[i].row !== er || beats[i].last !== (i == n - 1) || beats[i].data !== mem[er] || beats[i].c - t0 != 3 + i) begin
                fails++;
                $display("FAIL %s_row%0d row %0d want %0d, last %b want %b, data %h want %h, cycle %0d want %0d",
                         nm, i, beats[i].row, er, beats[i].last, i == n - 1, beats[i].data[31:0], mem[er][31:0], beats[i].c - t0, 3 + i);
            end
        end
        tests += 2;
        if (done_cyc.size() != 1 || done_cyc[0] - t0 != n + 3) begin
            fails++; $display("FAIL %s_done pulses %0d first at cycle %0d want 1 pulse at %0d", nm, done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : -1, n + 3);
        end
        if (busy_cnt != n + 2) begin fails++; $display("FAIL %s_busy high %0d cycles want %0d", nm, busy_cnt, n + 2); end
    endtask

    // Random backpressure: every row exactly once, in order, and never more than 2 outstanding
    task automatic test_backpressure(input string nm, input logic [AW-1:0] sr, input int n);
        int t0; bit to; logic [AW-1:0] er;
        run(sr, n, 1, t0, to);
        tests++;
        if (beats.size() != n) begin fails++; $display("FAIL %s_count got %0d want %0d", nm, beats.size(), n); end
        for (int i = 0; i < beats.size() && i < n; i++) begin
            er = 6'(int'(sr) + i);
            tests++;
            if (beats[i].row !== er || beats[i].last !== (i == n - 1) || beats[i].data !== mem[er]) begin
                fails++;
                $display("FAIL %s_row%0d row %0d want %0d, last %b want %b, data %h want %h",
                         nm, i, beats[i].row, er, beats[i].last, i == n - 1, beats[i].data[31:0], mem[er][31:0]);
            end
        end
        tests++;
        if (bound_viol != 0) begin fails++; $display("FAIL %s_credit reads issued beyond 2 outstanding: %0d want 0", nm, bound_viol); end
    endtask

    task automatic test_zero_rows();
        int t0; bit to;
        run(6'($urandom), 0, 0, t0, to);
        repeat (3) tick();
        tests += 3;
        if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1) begin
            fails++; $display("FAIL zero_done pulses %0d at cycle %0d want 1 pulse at 1", done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : -1);
        end
        if (en_cnt != 0)    begin fails++; $display("FAIL zero_mem_en cycles %0d want 0", en_cnt); end
        if (valid_cnt != 0) begin fails++; $display("FAIL zero_m_valid cycles %0d want 0", valid_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int t0; bit to; logic [AW-1:0] sr, er;
        clear_mon();
        tick();
        start = 1; start_row = 6'($urandom); num_rows = 7'd10; m_ready = 1; t0 = cyc;
        tick();
        start = 0;
        while (cyc - t0 < 4) tick();
        rst = 1;
        #1;
        tests += 6;
        if (mem_en_b !== 1'b0) begin fails++; $display("FAIL midrst_mem_en_b got %b want 0", mem_en_b); end
        if (mem_addr_b !== '0) begin fails++; $display("FAIL midrst_mem_addr_b got %0d want 0", mem_addr_b); end
        if (m_valid !== 1'b0)  begin fails++; $display("FAIL midrst_m_valid got %b want 0", m_valid); end
        if (m_data !== '0 || m_row !== '0 || m_last !== 1'b0) begin fails++; $display("FAIL midrst_m_payload row %0d last %b data %h want 0", m_row, m_last, m_data[31:0]); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (done !== 1'b0)     begin fails++; $display("FAIL midrst_done got %b want 0", done); end
        tick(); tick();
        rst = 0;
        sr = 6'($urandom);
        run(sr, 5, 0, t0, to);
        tests++;
        if (beats.size() != 5) begin fails++; $display("FAIL midrst_rerun_count got %0d want 5", beats.size()); end
        for (int i = 0; i < beats.size() && i < 5; i++) begin
            er = 6'(int'(sr) + i);
            tests++;
            if (beats[i].row !== er || beats[i].data !== mem[er] || beats[i].c - t0 != 3 + i) begin
                fails++; $display("FAIL midrst_rerun_row%0d row %0d want %0d, cycle %0d want %0d", i, beats[i].row, er, beats[i].c - t0, 3 + i);
            end
        end
    endtask

    // Second start lands in the cycle done is high
    task automatic test_back_to_back();
        int t1; int n1 = 3, n2 = 5; bit hit = 0;
        logic [AW-1:0] s1 = 6'($urandom), s2 = 6'($urandom), er;
        clear_mon();
        tick();
        start = 1; start_row = s1; num_rows = 7'(n1); m_ready = 1;
        tick();
        start = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin hit = 1; break; end
            tick();
        end
        start = 1; start_row = s2; num_rows = 7'(n2); t1 = cyc;
        tick();
        start = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_cyc.size() >= 2) break;
            tick();
        end
        tests += 3;
        if (!hit) begin fails++; $display("FAIL b2b_first_done not seen within 100 cycles"); end
        if (done_cyc.size() != 2) begin fails++; $display("FAIL b2b_done pulses %0d want 2", done_cyc.size()); end
        if (beats.size() != n1 + n2) begin fails++; $display("FAIL b2b_count got %0d want %0d", beats.size(), n1 + n2); end
        for (int i = 0; i < beats.size() && i < n1 + n2; i++) begin
            er = (i < n1) ? 6'(int'(s1) + i) : 6'(int'(s2) + i - n1);
            tests++;
            if (beats[i].row !== er || beats[i].data !== mem[er] || beats[i].last !== (i == n1 - 1 || i == n1 + n2 - 1)) begin
                fails++; $display("FAIL b2b_row%0d row %0d want %0d, last %b", i, beats[i].row, er, beats[i].last);
            end
        end
        tests++;
        if (beats.size() > n1 && beats[n1].c - t1 != 3) begin fails++; $display("FAIL b2b_latency got %0d want 3", beats[n1].c - t1); end
    endtask

`ifdef INPUT_FETCH_PERF_EN
    task automatic test_perf();
        int t0;
        clear_mon();
        tick();
        start = 1; start_row = 6'($urandom); num_rows = 7'd2; m_ready = 0; t0 = cyc;
        tick();
        start = 0;
        while (cyc - t0 < 8) tick();
        m_ready = 1;
        for (int k = 0; k < 50; k++) begin
            if (done_cyc.size() > 0) break;
            tick();
        end
        tests++;
        if (perf_stall_cycles !== 32'd5) begin fails++; $display("FAIL perf_count got %0d want 5", perf_stall_cycles); end
        start = 1; num_rows = 7'd1;
        tick();
        start = 0;
        tests++;
        if (perf_stall_cycles !== 32'd0) begin fails++; $display("FAIL perf_clear got %0d want 0", perf_stall_cycles); end
        repeat (6) tick();
    endtask
`endif

    initial begin
        for (int r = 0; r < 64; r++)
            for (int w = 0; w < RW / 32; w++) mem[r][w*32 +: 32] = $urandom;
        test_reset();
        test_stream("basic", 6'd0, 4);
        test_stream("wrap", 6'd62, 4);
        test_backpressure("full64", 6'($urandom), 64);
        test_zero_rows();
        test_reset_mid_run();
        test_back_to_back();
`ifdef INPUT_FETCH_PERF_EN
        test_perf();
`endif
        for (int j = 0; j < 4; j++) test_backpressure("rand", 6'($urandom), int'($urandom_range(1, 64)));
        test_stream("single", 6'd63, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_row_fetcher.md
# input_row_fetcher

Read sequencer directly downstream of the 64-row × 2048-bit input dual-port memory. On a start pulse it walks that memory's wide read port (port B) over a programmable run of rows, compensates for the memory's 1-cycle read latency, and presents each 2048-bit row (64 packed 32-bit words) to the matmul compute array over a valid/ready stream. A credit-limited 2-entry buffer provides backpressure, so no row is lost or duplicated when the array stalls.

## Interface
- ROW_W, 2048, row width in bits (64 × 32-bit words)
- ADDR_W, 6, port-B row address width (64 rows)
- FIFO_DEPTH, 2, output buffer entries; the read credit limit equals this value

- clk  in  1  single clock; also drives memory port B
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- start_row  in  ADDR_W  first row to read; captured on start
- num_rows  in  ADDR_W+1  row count, 0..64; captured on start
- mem_en_b  out  1  port-B read enable (combinational from state and credit)
- mem_addr_b  out  ADDR_W  port-B row address
- mem_dout_b  in  ROW_W  port-B data, valid 1 cycle after mem_en_b
- m_valid  out  1  output row valid
- m_ready  in  1  consumer accepts the row
- m_data  out  ROW_W  row data, bit order exactly as delivered by port B
- m_row  out  ADDR_W  memory row index of m_data
- m_last  out  1  marks the final row of the run
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the run completes

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: on start with num_rows > 0, capture start_row and num_rows, then go to FETCH. With num_rows == 0, pulse done on the next cycle and stay in IDLE.
- FETCH: issue a read (mem_en_b=1, mem_addr_b=current row) in every cycle where occupancy + in_flight < FIFO_DEPTH.
  - On each issue, the row address increments modulo 64, so runs wrap 63→0, and the remaining count decrements.
  - The issue that consumes the last remaining row moves the FSM to DRAIN.
- in_flight is a 1-bit flag set on each issue. In the following cycle, mem_dout_b is pushed into the FIFO together with its row index and a last flag.
- DRAIN: no further reads. On m_valid & m_ready & m_last, pulse done on the next cycle and return to IDLE.
- start is ignored while busy.
- The output stream is the FIFO head. Entries are popped on m_valid & m_ready. A push and a pop in the same cycle are both honoured.
- Reset mid-run clears state, count, in_flight and the FIFO. Data returned by a read issued before reset is discarded.
- Reset values: mem_en_b 0, mem_addr_b 0, m_valid 0, m_data 0, m_row 0, m_last 0, busy 0, done 0, perf_stall_cycles 0.

## Timing
- Cycle 0: start sampled.
- Cycle 1: FETCH, first read issued.
- Cycle 2: mem_dout_b valid.
- Cycle 3: m_valid high. Start-to-first-row latency is 3 cycles.
- With m_ready held high the sustained rate is 1 row/cycle. N rows give m_last in cycle N+2 and done in cycle N+3.
- If m_ready is low, at most FIFO_DEPTH rows are buffered or in flight, and issue stalls until a pop frees a credit.
- m_data, m_row and m_last are held stable while m_valid & !m_ready.
- The next start is accepted in the cycle done is high at the earliest, because the FSM is already in IDLE.

## Configuration
- INPUT_FETCH_PERF_EN
  - Defined: adds output perf_stall_cycles [31:0]. It counts cycles with m_valid & !m_ready, saturates at 2^32−1, and clears on an accepted start and on rst.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package input_fetch_pkg holds the FSM state enum (IDLE, FETCH, DRAIN) and the ROW_W / ADDR_W constants shared with the input memory and the compute array.
- Sub-module row_fifo: a FIFO_DEPTH-entry synchronous FIFO of width ROW_W+ADDR_W+1, with full/empty/count outputs and async active-high reset.
- The top level contains the FSM, address/count registers, in_flight flag and credit check.

## Test plan
- start_row=0, num_rows=4, m_ready=1 → rows 0,1,2,3 on m_valid in cycles 3–6, m_last in cycle 6, done in cycle 7.
- start_row=62, num_rows=4 → m_row sequence 62,63,0,1; data matches the preloaded memory contents.
- num_rows=64, m_ready toggling 1-0-0-1 pseudo-randomly → all 64 rows delivered exactly once and in order, and mem_en_b never asserts while occupancy + in_flight = 2.
- num_rows=0 → done pulses in cycle 1, and no mem_en_b and no m_valid are ever asserted.
- rst asserted in cycle 4 of a 10-row run → all outputs return to their reset values immediately; a new run then starts cleanly with no stale row emitted.
- With INPUT_FETCH_PERF_EN, num_rows=2 and m_ready low for 5 cycles after first valid → perf_stall_cycles = 5.
